// File: rtl/spart_pkg.sv
// Shared definitions for the SPART baud-rate generator: controller states,
// bus register codes and the power-on divisor.
package spart_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        OFF  = 2'd2
    } spart_state_t;

    localparam logic [1:0]  ADDR_DB_LOW  = 2'b10;
    localparam logic [1:0]  ADDR_DB_HIGH = 2'b11;

    // 16x oversample tick period minus one
    localparam logic [15:0] DEFAULT_DIV  = 16'd162;

endpackage

// File: rtl/spart_baud_ctrl_counter.sv
// Reloadable 16-bit down-counter; flags the cycle in which it sits at zero so
// the owner can register a one-cycle tick from it.
module baud_counter #(
    parameter logic [15:0] RESET_VALUE = 16'd162
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic [15:0] reload_value,
    output logic        zero
);

    logic [15:0] count;

    // An explicit load always takes priority over the natural zero reload.
    assign zero = enable && !load && (count == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (!enable) begin
            count <= 16'd0;
        end else if (count == 16'd0) begin
            count <= reload_value;
        end else begin
            count <= count - 16'd1;
        end
    end

endmodule

// File: rtl/spart_baud_ctrl.sv
// SPART baud generator: divisor register pair with staged low byte, rx/tx tick
// generation and receiver phase realignment.
module spart_baud_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV,
    parameter logic [4:0]  OVERSAMPLE  = 5'd16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] databus_in,
    input  logic       rx_resync,
    output logic       rx_tick,
    output logic       tx_tick,
    output logic       div_pending,
    output logic       baud_off
);

    import spart_pkg::*;

    localparam logic [3:0] OVS_LAST = 4'(OVERSAMPLE - 5'd1);
    localparam logic [3:0] OVS_MID  = 4'(OVERSAMPLE >> 1);

    spart_state_t state;
    spart_state_t next_state;

    logic [15:0] divisor;
    logic [7:0]  shadow_low;
    logic [3:0]  ovs;

    logic        bus_write;
    logic        db_low_wr;
    logic        db_high_wr;
    logic [15:0] commit_value;
    logic        baud_en;
    logic        resync_ok;
    logic        cnt_load;
    logic [15:0] cnt_load_value;
    logic        tick_event;

    assign bus_write    = iocs && !iorw;
    assign db_low_wr    = bus_write && (ioaddr == ADDR_DB_LOW);
    assign db_high_wr   = bus_write && (ioaddr == ADDR_DB_HIGH);
    assign commit_value = {databus_in, shadow_low};

    // A zero divisor parks the generator; resync is meaningless without a baud.
    assign baud_en   = (divisor != 16'd0) && (state != OFF);
    assign resync_ok = rx_resync && !db_high_wr && baud_en;

    assign cnt_load       = db_high_wr || resync_ok;
    assign cnt_load_value = db_high_wr ? commit_value : (divisor >> 1);

    baud_counter #(
        .RESET_VALUE (DEFAULT_DIV)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (baud_en),
        .load         (cnt_load),
        .load_value   (cnt_load_value),
        .reload_value (divisor),
        .zero         (tick_event)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (db_high_wr) begin
            next_state = (commit_value == 16'd0) ? OFF : RUN;
        end else if (db_low_wr) begin
            next_state = PEND;
        end
    end

    // Status flags and ticks are registered so no input reaches an output
    // combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor     <= DEFAULT_DIV;
            shadow_low  <= DEFAULT_DIV[7:0];
            ovs         <= 4'd0;
            rx_tick     <= 1'b0;
            tx_tick     <= 1'b0;
            div_pending <= 1'b0;
            baud_off    <= 1'b0;
        end else begin
            div_pending <= (next_state == PEND);
            baud_off    <= (next_state == OFF);
            rx_tick     <= tick_event;
            tx_tick     <= tick_event && (ovs == OVS_LAST);

            if (db_low_wr) begin
                shadow_low <= databus_in;
            end
            if (db_high_wr) begin
                divisor <= commit_value;
            end

            if (db_high_wr || !baud_en) begin
                ovs <= 4'd0;
            end else if (resync_ok) begin
                ovs <= OVS_MID;
            end else if (tick_event) begin
                ovs <= (ovs == OVS_LAST) ? 4'd0 : ovs + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_spart_baud_ctrl.sv
// Directed bench for spart_baud_ctrl: bus-write vector table for the divisor
// FSM plus hand sequences timing rx/tx ticks, resync and reset.
module tb_spart_baud_ctrl;

    logic       clk;
    logic       rst_n;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus_in;
    logic       rx_resync;
    logic       rx_tick;
    logic       tx_tick;
    logic       div_pending;
    logic       baud_off;

    int total = 0;
    int bad = 0;
    int stray_tx = 0;

    typedef struct {
        logic       cs;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
        logic       exp_pending;
        logic       exp_off;
    } vec_t;

    vec_t vecs[9];

    spart_baud_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iocs        (iocs),
        .iorw        (iorw),
        .ioaddr      (ioaddr),
        .databus_in  (databus_in),
        .rx_resync   (rx_resync),
        .rx_tick     (rx_tick),
        .tx_tick     (tx_tick),
        .div_pending (div_pending),
        .baud_off    (baud_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [7:0] data);
        iocs = 1'b1;
        iorw = 1'b0;
        ioaddr = addr;
        databus_in = data;
        step();
        iocs = 1'b0;
        iorw = 1'b1;
    endtask

    // Applies one bus cycle from the table and checks the registered flags.
    task automatic applyStimulus(input int idx, input vec_t v);
        iocs = v.cs;
        iorw = v.rw;
        ioaddr = v.addr;
        databus_in = v.data;
        step();
        iocs = 1'b0;
        iorw = 1'b1;
        checkOutput($sformatf("vec%0d_pending", idx), int'(div_pending), int'(v.exp_pending));
        checkOutput($sformatf("vec%0d_off", idx), int'(baud_off), int'(v.exp_off));
    endtask

    task automatic wait_rx(input int limit, output int cycles, output logic tx_seen);
        cycles = 0;
        do begin
            step();
            cycles++;
            if (tx_tick && !rx_tick) stray_tx++;
        end while (!rx_tick && cycles < limit);
        tx_seen = tx_tick;
    endtask

    // Times n consecutive rx ticks of the given period; tx expected on tick tx_at.
    task automatic check_ticks(input string name, input int n, input int period, input int tx_at);
        int   cyc;
        logic txs;
        for (int k = 1; k <= n; k++) begin
            wait_rx(period + 20, cyc, txs);
            checkOutput($sformatf("%s_period%0d", name, k), cyc, period);
            checkOutput($sformatf("%s_tx%0d", name, k), int'(txs), int'(k == tx_at));
        end
    endtask

    initial begin
        int   cyc;
        int   rx_count;
        int   tx_count;
        logic txs;

        vecs[0] = '{1'b1, 1'b1, 2'b10, 8'h99, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 2'b10, 8'h77, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 8'h55, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'b10, 8'h33, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 2'b10, 8'h04, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 2'b11, 8'h01, 1'b0, 1'b0};

        rst_n = 1'b1;
        iocs = 1'b0;
        iorw = 1'b1;
        ioaddr = 2'b00;
        databus_in = 8'h00;
        rx_resync = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_rx_tick", int'(rx_tick), 0);
        checkOutput("reset_tx_tick", int'(tx_tick), 0);
        checkOutput("reset_pending", int'(div_pending), 0);
        checkOutput("reset_off", int'(baud_off), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] default divisor after reset release");
        check_ticks("default", 16, 163, 16);

        $display("[TB] low byte staged, ticks undisturbed");
        write_reg(2'b10, 8'h04);
        wait_rx(200, cyc, txs);
        checkOutput("pend_first_gap", cyc, 162);
        wait_rx(200, cyc, txs);
        checkOutput("pend_period", cyc, 163);
        checkOutput("pend_flag", int'(div_pending), 1);

        $display("[TB] register table, commit divisor 4");
        for (int i = 0; i <= 5; i++) applyStimulus(i, vecs[i]);
        check_ticks("div4", 16, 5, 16);

        $display("[TB] zero divisor turns baud off");
        for (int i = 6; i <= 7; i++) applyStimulus(i, vecs[i]);
        rx_count = 0;
        tx_count = 0;
        for (int c = 0; c < 1000; c++) begin
            rx_resync = (c == 500);
            step();
            if (rx_tick) rx_count++;
            if (tx_tick) tx_count++;
        end
        rx_resync = 1'b0;
        checkOutput("off_rx_count", rx_count, 0);
        checkOutput("off_tx_count", tx_count, 0);
        checkOutput("off_flag_held", int'(baud_off), 1);
        applyStimulus(8, vecs[8]);
        check_ticks("div256", 2, 257, 0);

        $display("[TB] resync with divisor 9");
        write_reg(2'b10, 8'h09);
        write_reg(2'b11, 8'h00);
        wait_rx(40, cyc, txs);
        checkOutput("div9_first", cyc, 10);
        repeat (3) step();
        rx_resync = 1'b1;
        step();
        rx_resync = 1'b0;
        wait_rx(40, cyc, txs);
        checkOutput("resync_first", cyc, 5);
        checkOutput("resync_tx1", int'(txs), 0);
        for (int k = 2; k <= 8; k++) begin
            wait_rx(40, cyc, txs);
            checkOutput($sformatf("resync_period%0d", k), cyc, 10);
            checkOutput($sformatf("resync_tx%0d", k), int'(txs), int'(k == 8));
        end

        $display("[TB] commit and resync in the same cycle");
        write_reg(2'b10, 8'h06);
        rx_resync = 1'b1;
        write_reg(2'b11, 8'h00);
        rx_resync = 1'b0;
        check_ticks("collide", 16, 7, 16);

        $display("[TB] reset during pending update");
        write_reg(2'b10, 8'h04);
        write_reg(2'b11, 8'h00);
        write_reg(2'b10, 8'h20);
        wait_rx(40, cyc, txs);
        checkOutput("prereset_rx", int'(rx_tick), 1);
        checkOutput("prereset_pending", int'(div_pending), 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rx_tick", int'(rx_tick), 0);
        checkOutput("async_tx_tick", int'(tx_tick), 0);
        checkOutput("async_pending", int'(div_pending), 0);
        checkOutput("async_off", int'(baud_off), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_rx(200, cyc, txs);
        checkOutput("rerelease_first", cyc, 163);
        checkOutput("rerelease_pending", int'(div_pending), 0);
        write_reg(2'b11, 8'h00);
        wait_rx(200, cyc, txs);
        checkOutput("shadow_default_commit", cyc, 163);
        checkOutput("shadow_default_off", int'(baud_off), 0);

        checkOutput("stray_tx_ticks", stray_tx, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spart_baud_ctrl.md
SPART_BAUD_CTRL -- requirements
Module: spart_baud_ctrl

Interface
REQ-001 Parameter DEFAULT_DIV, 16'd162: divisor loaded at reset (16x oversample tick period minus 1).
REQ-002 Parameter OVERSAMPLE, 5'd16: rx_tick pulses per tx_tick.
REQ-003 Port clk, input, 1: the single clock; all state changes on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port iocs, input, 1: chip select from the processor bus.
REQ-006 Port iorw, input, 1: 0 = write, 1 = read.
REQ-007 Port ioaddr, input, 2: register select; 2'b10 = DB_LOW, 2'b11 = DB_HIGH; other codes ignored by this block.
REQ-008 Port databus_in, input, 8: write data.
REQ-009 Port rx_resync, input, 1: one-cycle pulse from the receiver on start-bit detect; realigns the phase.
REQ-010 Port rx_tick, output, 1: one-cycle 16x sample enable.
REQ-011 Port tx_tick, output, 1: one-cycle bit-period enable.
REQ-012 Port div_pending, output, 1: high while a low byte is latched and the high byte is not yet written.
REQ-013 Port baud_off, output, 1: high while the committed divisor is zero; both ticks are then suppressed.

Function
REQ-014 A write is iocs && !iorw; a DB_LOW write latches databus_in into shadow_low.
REQ-015 A DB_HIGH write commits divisor = {databus_in, shadow_low} on the same edge; shadow_low is used even when no DB_LOW write preceded it.
REQ-016 FSM states: RUN, PEND, OFF.
REQ-017 Transitions: RUN/OFF -> PEND on a DB_LOW write.
REQ-018 Transitions: any state -> RUN on a DB_HIGH write with a nonzero committed value.
REQ-019 Transitions: any state -> OFF on a DB_HIGH write with a zero committed value.
REQ-020 PEND -> PEND on a repeated DB_LOW write; the newest low byte wins.
REQ-021 In PEND the down-counter keeps running on the old divisor; ticks continue undisturbed.
REQ-022 The 16-bit down-counter reloads with the divisor when it reaches 0, and rx_tick asserts for exactly that cycle (period = divisor+1 clocks).
REQ-023 On commit, the counter loads the new divisor and the oversample counter clears; the first rx_tick follows divisor+1 cycles after the commit edge.
REQ-024 The 4-bit oversample counter increments on each rx_tick and wraps 15->0; tx_tick = rx_tick && (ovs == 15), a coincident single-cycle pulse.
REQ-025 When rx_resync is asserted, the down-counter loads divisor>>1 and ovs loads 8, placing the next tx_tick at mid-bit; this is ignored in OFF.
REQ-026 A commit and rx_resync in the same cycle: the commit wins and rx_resync is dropped.
REQ-027 In OFF, the counters hold at 0 and rx_tick = tx_tick = 0.
REQ-028 div_pending = (state == PEND); baud_off = (state == OFF); both are registered.
REQ-029 Outputs are registered, with no combinational path from inputs to outputs.

Reset
REQ-030 On rst_n low, asynchronously: divisor = DEFAULT_DIV, counter = DEFAULT_DIV, shadow_low = DEFAULT_DIV[7:0], ovs = 0, state = RUN.
REQ-031 On rst_n low, asynchronously: rx_tick = 0, tx_tick = 0, div_pending = 0, baud_off = 0.
REQ-032 The first rx_tick occurs DEFAULT_DIV+1 cycles after rst_n deasserts.
REQ-033 Reset asserted during PEND discards shadow_low, and the block returns to the default divisor.

Structure
REQ-034 The shared package spart_pkg holds:
- the state enum {RUN, PEND, OFF};
- the ioaddr codes ADDR_DB_LOW and ADDR_DB_HIGH;
- the DEFAULT_DIV constant.
REQ-035 One sub-module, baud_counter, holds the 16-bit reloadable down-counter with load/value inputs and a zero-pulse output; the FSM, shadow register and oversample logic stay in spart_baud_ctrl.

Verification
REQ-036 Reset release with defaults -> rx_tick every 163 cycles; tx_tick every 2608 cycles, coincident with every 16th rx_tick.
REQ-037 Write DB_LOW=0x04 -> div_pending=1 and tick spacing unchanged; then write DB_HIGH=0x00 -> div_pending=0 and rx_tick every 5 cycles, the first one 5 cycles after the commit.
REQ-038 Write DB_LOW=0x00 then DB_HIGH=0x00 -> baud_off=1 and no ticks for 1000 cycles; then write DB_HIGH=0x01 -> baud_off=0 and rx_tick period 257.
REQ-039 Divisor 9, pulse rx_resync mid-period -> next rx_tick 5 cycles later; tx_tick occurs on the 8th rx_tick after the resync.
REQ-040 DB_HIGH write and rx_resync in the same cycle -> commit timing per REQ-023, with the resync ignored.
REQ-041 Assert rst_n low during PEND with divisor 4 active -> all outputs 0 immediately; after release, period 163 and div_pending=0.
